// File: rtl/intr_pending_ctrl_if.sv
// Bus bundle between the interrupt front-end and its neighbours: APB slave port,
// raw peripheral lines, active-interrupt bus and the controller's service handshake.
interface intr_pending_ctrl_if #(
  parameter int NUM_INTRPT   = 16,
  parameter int INTRPT_WIDTH = 4
);
  // APB-style register port
  logic                    psel_i;
  logic                    penable_i;
  logic                    pwrite_i;
  logic [2:0]              paddr_i;
  logic [NUM_INTRPT-1:0]   pwdata_i;
  logic [NUM_INTRPT-1:0]   prdata_o;
  logic                    pready_o;
  logic                    perror_o;

  // Interrupt lines and controller handshake
  logic [NUM_INTRPT-1:0]   irq_i;
  logic [NUM_INTRPT-1:0]   intr_active_o;
  logic [INTRPT_WIDTH-1:0] intr_id_i;
  logic                    intr_valid_i;
  logic                    intr_srvcd_i;

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  irq_i, intr_id_i, intr_valid_i, intr_srvcd_i,
    output prdata_o, pready_o, perror_o, intr_active_o
  );

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output irq_i, intr_id_i, intr_valid_i, intr_srvcd_i,
    input  prdata_o, pready_o, perror_o, intr_active_o
  );
endinterface

// File: rtl/intr_pending_ctrl.sv
// Interrupt front-end: synchronises raw lines, latches them edge- or level-sensitive,
// masks them onto the controller's active bus and retires edge requests on service.
module intr_pending_ctrl #(
  parameter int NUM_INTRPT   = 16,
  parameter int INTRPT_WIDTH = 4
) (
  input  logic                pclk_i,
  input  logic                prst_n_i,
  intr_pending_ctrl_if.slave  bus
);

  typedef logic [NUM_INTRPT-1:0] vec_t;

  localparam logic [2:0] ADDR_MASK = 3'd0;
  localparam logic [2:0] ADDR_MODE = 3'd1;
  localparam logic [2:0] ADDR_PEND = 3'd2;
  localparam logic [2:0] ADDR_OVR  = 3'd3;
  localparam logic [2:0] ADDR_RAW  = 3'd4;

  // Synchroniser and edge-history flops
  vec_t s1_q, s2_q, s3_q;

  // Architectural state
  vec_t mask_q, mask_d;
  vec_t mode_q, mode_d;
  vec_t pend_q, pend_d;
  vec_t ovr_q,  ovr_d;

  // APB response registers
  vec_t prdata_q, prdata_d;
  logic pready_q, pready_d;
  logic perror_q, perror_d;
  logic done_q,   done_d;

  // Decode and per-line helpers
  logic access, exec;
  logic addr_valid, wr_ok;
  logic wr_mask, wr_mode, wr_pend, wr_ovr;
  vec_t rd_data;
  vec_t rise, svc_hit, mode_chg, pend_clr, ovr_w1c;

  assign rise = s2_q & ~s3_q;

  // ---------------------------------------------------------------------------
  // APB decode. done_q blocks a second execution while the master keeps the
  // access phase asserted after the response; it drops once psel/penable go away.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    access     = bus.psel_i & bus.penable_i;
    exec       = access & ~pready_q & ~done_q;
    done_d     = access & (done_q | exec);
    addr_valid = (bus.paddr_i <= ADDR_RAW);
    wr_ok      = exec & bus.pwrite_i & (bus.paddr_i < ADDR_RAW);

    wr_mask = wr_ok & (bus.paddr_i == ADDR_MASK);
    wr_mode = wr_ok & (bus.paddr_i == ADDR_MODE);
    wr_pend = wr_ok & (bus.paddr_i == ADDR_PEND);
    wr_ovr  = wr_ok & (bus.paddr_i == ADDR_OVR);

    rd_data = '0;
    case (bus.paddr_i)
      ADDR_MASK: rd_data = mask_q;
      ADDR_MODE: rd_data = mode_q;
      ADDR_PEND: rd_data = pend_q;
      ADDR_OVR:  rd_data = ovr_q;
      ADDR_RAW:  rd_data = s2_q;
      default:   rd_data = '0;
    endcase

    pready_d = exec;
    perror_d = exec & (~addr_valid | (bus.pwrite_i & (bus.paddr_i == ADDR_RAW)));
    prdata_d = (exec & ~bus.pwrite_i) ? rd_data : '0;
  end

  // Service handshake decode; ids beyond the implemented lines match nothing.
  always_comb begin
    svc_hit = '0;
    for (int n = 0; n < NUM_INTRPT; n++) begin
      svc_hit[n] = bus.intr_valid_i & bus.intr_srvcd_i &
                   (bus.intr_id_i == INTRPT_WIDTH'(n));
    end
  end

  // ---------------------------------------------------------------------------
  // Per-line pending / overrun update. A mode change wipes the line for one
  // edge; afterwards the new rule applies. In edge mode a rise beats any clear.
  // ---------------------------------------------------------------------------
  always_comb begin
    mask_d   = wr_mask ? bus.pwdata_i : mask_q;
    mode_d   = wr_mode ? bus.pwdata_i : mode_q;
    mode_chg = wr_mode ? (bus.pwdata_i ^ mode_q) : '0;
    pend_clr = svc_hit | (wr_pend ? bus.pwdata_i : '0);
    ovr_w1c  = wr_ovr ? bus.pwdata_i : '0;

    pend_d = pend_q;
    ovr_d  = ovr_q;
    for (int n = 0; n < NUM_INTRPT; n++) begin
      if (mode_chg[n]) begin
        pend_d[n] = 1'b0;
        ovr_d[n]  = 1'b0;
      end else if (mode_q[n]) begin
        pend_d[n] = rise[n] | (pend_q[n] & ~pend_clr[n]);
        ovr_d[n]  = (rise[n] & pend_q[n] & ~pend_clr[n]) | (ovr_q[n] & ~ovr_w1c[n]);
      end else begin
        pend_d[n] = s2_q[n];
        ovr_d[n]  = ovr_q[n] & ~ovr_w1c[n];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. The synchroniser chain is reset as well so RAW and the
  // level-mode pending bits read 0 straight out of reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      ovr_q    <= '0;
      prdata_q <= '0;
      pready_q <= 1'b0;
      perror_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      s1_q     <= bus.irq_i;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      prdata_q <= prdata_d;
      pready_q <= pready_d;
      perror_q <= perror_d;
      done_q   <= done_d;
    end
  end

  assign bus.prdata_o      = prdata_q;
  assign bus.pready_o      = pready_q;
  assign bus.perror_o      = perror_q;
  assign bus.intr_active_o = pend_q & mask_q;

endmodule

// File: tb/tb_intr_pending_ctrl.sv
// Self-checking bench for intr_pending_ctrl: table-driven register vectors plus
// hand-written interrupt sequences, APB responses checked through a scoreboard queue.
module tb_intr_pending_ctrl;
  localparam int N = 16;
  localparam int W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  intr_pending_ctrl_if #(.NUM_INTRPT(N), .INTRPT_WIDTH(W)) bus ();

  intr_pending_ctrl #(.NUM_INTRPT(N), .INTRPT_WIDTH(W)) dut (
    .pclk_i   (clk),
    .prst_n_i (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    string       name;
    bit          is_read;
    logic [15:0] rdata;
    bit          err;
  } exp_t;

  typedef struct {
    string       name;
    bit          wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    bit          err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One APB transfer; expected response is queued at issue and popped on pready.
  task automatic apb(input string nm, input bit wr, input logic [2:0] a,
                     input logic [15:0] d, input logic [15:0] exp_rd, input bit exp_err);
    exp_t e;
    bit   got;
    e.name = nm; e.is_read = !wr; e.rdata = exp_rd; e.err = exp_err;
    sb.push_back(e);
    bus.psel_i    = 1'b1;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = wr;
    bus.paddr_i   = a;
    bus.pwdata_i  = d;
    tick();
    bus.penable_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = bus.pready_o;
    end
    e = sb.pop_front();
    if (!got) begin
      check({e.name, " pready timeout"}, 32'(got), 32'd1);
    end else begin
      if (e.is_read) check({e.name, " rdata"}, 32'(bus.prdata_o), 32'(e.rdata));
      check({e.name, " perror"}, 32'(bus.perror_o), 32'(e.err));
    end
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
  endtask

  task automatic pulse_irq(input int n);
    bus.irq_i[n] = 1'b1;
    tick(2);
    bus.irq_i[n] = 1'b0;
    tick(3);
  endtask

  task automatic service(input logic [W-1:0] id);
    bus.intr_id_i    = id;
    bus.intr_valid_i = 1'b1;
    bus.intr_srvcd_i = 1'b1;
    tick();
    bus.intr_valid_i = 1'b0;
    bus.intr_srvcd_i = 1'b0;
  endtask

  int cnt;

  initial begin
    vecs[0]  = '{"rd MASK",  1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{"rd MODE",  1'b0, 3'd1, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{"rd PEND",  1'b0, 3'd2, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{"rd OVR",   1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0};
    vecs[4]  = '{"rd RAW",   1'b0, 3'd4, 16'h0000, 16'h0000, 1'b0};
    vecs[5]  = '{"rd a5",    1'b0, 3'd5, 16'h0000, 16'h0000, 1'b1};
    vecs[6]  = '{"rd a6",    1'b0, 3'd6, 16'h0000, 16'h0000, 1'b1};
    vecs[7]  = '{"rd a7",    1'b0, 3'd7, 16'h0000, 16'h0000, 1'b1};
    vecs[8]  = '{"wr a4",    1'b1, 3'd4, 16'hFFFF, 16'h0000, 1'b1};
    vecs[9]  = '{"wr a5",    1'b1, 3'd5, 16'hFFFF, 16'h0000, 1'b1};
    vecs[10] = '{"wr a7",    1'b1, 3'd7, 16'hFFFF, 16'h0000, 1'b1};
    vecs[11] = '{"rd MASK2", 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0};

    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    bus.paddr_i = '0;  bus.pwdata_i = '0;    bus.irq_i = '0;
    bus.intr_id_i = '0; bus.intr_valid_i = 1'b0; bus.intr_srvcd_i = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();

    // Asynchronous reset with activity in flight
    apb("wr MASK ffff", 1'b1, 3'd0, 16'hFFFF, 16'h0, 1'b0);
    bus.irq_i = 16'hFFFF;
    tick(3);
    check("pre-reset active", 32'(bus.intr_active_o), 32'h0000FFFF);
    #4;
    rst_n = 1'b0;
    #1;
    check("reset active",  32'(bus.intr_active_o), 32'h0);
    check("reset pready",  32'(bus.pready_o),      32'h0);
    check("reset perror",  32'(bus.perror_o),      32'h0);
    check("reset prdata",  32'(bus.prdata_o),      32'h0);
    bus.irq_i = '0;
    tick();
    rst_n = 1'b1;
    tick(3);

    foreach (vecs[i])
      apb(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);

    // Edge capture and service retirement on line 3
    apb("wr MASK 0008", 1'b1, 3'd0, 16'h0008, 16'h0, 1'b0);
    apb("wr MODE 0008", 1'b1, 3'd1, 16'h0008, 16'h0, 1'b0);
    bus.irq_i = 16'h0008;
    tick(2);
    check("edge before latency", 32'(bus.intr_active_o), 32'h0);
    bus.irq_i = '0;
    tick();
    check("edge captured 3rd edge", 32'(bus.intr_active_o), 32'h0008);
    tick(2);
    check("edge held", 32'(bus.intr_active_o), 32'h0008);
    service(4'd3);
    check("edge serviced", 32'(bus.intr_active_o), 32'h0);
    apb("rd OVR after svc", 1'b0, 3'd3, 16'h0, 16'h0000, 1'b0);

    // Overrun and set-wins on line 5
    apb("wr MODE 0028", 1'b1, 3'd1, 16'h0028, 16'h0, 1'b0);
    apb("wr MASK 0028", 1'b1, 3'd0, 16'h0028, 16'h0, 1'b0);
    pulse_irq(5);
    check("line5 active", 32'(bus.intr_active_o), 32'h0020);
    pulse_irq(5);
    apb("rd OVR overrun", 1'b0, 3'd3, 16'h0, 16'h0020, 1'b0);
    bus.irq_i[5] = 1'b1;
    tick(2);
    service(4'd5);
    bus.irq_i[5] = 1'b0;
    tick(3);
    apb("rd PEND set wins", 1'b0, 3'd2, 16'h0, 16'h0020, 1'b0);
    apb("rd OVR no new ovr", 1'b0, 3'd3, 16'h0, 16'h0020, 1'b0);
    apb("w1c OVR", 1'b1, 3'd3, 16'h0020, 16'h0, 1'b0);
    apb("rd OVR cleared", 1'b0, 3'd3, 16'h0, 16'h0000, 1'b0);
    apb("w1c PEND", 1'b1, 3'd2, 16'h0020, 16'h0, 1'b0);
    apb("rd PEND cleared", 1'b0, 3'd2, 16'h0, 16'h0000, 1'b0);

    // Masked line keeps pending; unmasking exposes it the next cycle
    apb("wr MODE 0228", 1'b1, 3'd1, 16'h0228, 16'h0, 1'b0);
    pulse_irq(9);
    check("line9 masked", 32'(bus.intr_active_o), 32'h0);
    apb("rd PEND line9", 1'b0, 3'd2, 16'h0, 16'h0200, 1'b0);
    apb("wr MASK 0200", 1'b1, 3'd0, 16'h0200, 16'h0, 1'b0);
    check("unmask next cycle", 32'(bus.intr_active_o), 32'h0200);

    // Access phase held for three cycles: one response, one execution
    bus.psel_i = 1'b1; bus.pwrite_i = 1'b1; bus.paddr_i = 3'd2;
    bus.pwdata_i = 16'h0200; bus.penable_i = 1'b0;
    tick();
    bus.penable_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cnt += int'(bus.pready_o);
    end
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    tick();
    cnt += int'(bus.pready_o);
    check("single pready pulse", 32'(cnt), 32'd1);
    check("held w1c cleared", 32'(bus.intr_active_o), 32'h0);

    // Level mode on line 0
    apb("wr MODE 0", 1'b1, 3'd1, 16'h0000, 16'h0, 1'b0);
    apb("wr MASK 0001", 1'b1, 3'd0, 16'h0001, 16'h0, 1'b0);
    bus.irq_i = 16'h0001;
    tick(3);
    check("level active", 32'(bus.intr_active_o), 32'h0001);
    service(4'd0);
    tick();
    check("level ignores svc", 32'(bus.intr_active_o), 32'h0001);
    apb("w1c PEND level", 1'b1, 3'd2, 16'h0001, 16'h0, 1'b0);
    apb("rd PEND level", 1'b0, 3'd2, 16'h0, 16'h0001, 1'b0);
    apb("rd OVR level", 1'b0, 3'd3, 16'h0, 16'h0000, 1'b0);
    apb("rd RAW", 1'b0, 3'd4, 16'h0, 16'h0001, 1'b0);
    apb("wr RAW err", 1'b1, 3'd4, 16'h0000, 16'h0, 1'b1);
    apb("rd RAW kept", 1'b0, 3'd4, 16'h0, 16'h0001, 1'b0);
    apb("rd a6 err", 1'b0, 3'd6, 16'h0, 16'h0000, 1'b1);
    bus.irq_i = '0;
    tick(2);
    check("level drop pending", 32'(bus.intr_active_o), 32'h0001);
    tick();
    check("level dropped", 32'(bus.intr_active_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
